// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: shared byte width, error byte, ALU opcode map and frame FSM state type
// for the UART/ALU byte-framed command controller.
package uart_alu_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam logic [7:0]  ERR_BYTE = 8'hEE;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_B,
    GET_CHK,
    EXEC,
    SEND,
    WAIT_TX
  } state_e;

endpackage

// File: rtl/uart_alu_frame_ctrl_frame_timer.sv
// frame_timer: inter-byte watchdog. clear_i reloads the down-counter; expire_o is high once
// TIMEOUT_CYC-1 cycles have elapsed since the last clear. TIMEOUT_CYC=0 disables it.
module frame_timer #(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic expire_o
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      assign expire_o = 1'b0;
    end else begin : g_on
      // Loaded with TIMEOUT_CYC-2 so that zero is reached in the (TIMEOUT_CYC-1)th cycle after a clear.
      localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC - 1) : 1;
      localparam int unsigned LOAD  = (TIMEOUT_CYC > 1) ? TIMEOUT_CYC - 2 : 0;

      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
          cnt_d = CNT_W'(LOAD);
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q <= CNT_W'(LOAD);
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expire_o = (cnt_q == '0);
    end
  endgenerate

endmodule

// File: rtl/uart_alu_frame_ctrl.sv
// uart_alu_frame_ctrl: receives opcode + LSB-first multi-byte operands, runs the external ALU,
// streams the result back byte by byte. Define UART_FRAME_CHECKSUM_EN for a trailing XOR checksum byte.
module uart_alu_frame_ctrl
  import uart_alu_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned OP_W        = 6,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done_tick,
  input  logic [7:0]        rx_data,
  input  logic              tx_done_tick,
  input  logic [DATA_W-1:0] alu_result,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              frame_err
);

  // DATA_W must be a multiple of 8 (>= 8); OP_W must not exceed 8.
  localparam int unsigned NBYTES = DATA_W / BYTE_W;
  localparam int unsigned BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BC_W-1:0] LAST_LANE = BC_W'(NBYTES - 1);

  state_e            state_q, state_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              tx_start_c, frame_err_c;
  logic              in_get, timer_clear, timer_expire, timeout;
  logic              last_lane, tx_last;
  int unsigned       lane_lsb;

`ifdef UART_FRAME_CHECKSUM_EN
  logic [BYTE_W-1:0] chk_q, chk_d;
  logic              err_q, err_d;
`endif

  assign lane_lsb  = BYTE_W * 32'(byte_cnt_q);
  assign last_lane = (byte_cnt_q == LAST_LANE);
  assign in_get    = state_q inside {GET_A, GET_B, GET_CHK};

`ifdef UART_FRAME_CHECKSUM_EN
  assign tx_last = last_lane || err_q;
`else
  assign tx_last = last_lane;
`endif

  // Timer only runs mid-frame; it is held reloaded everywhere else and on every received byte.
  assign timer_clear = rx_done_tick || !in_get;
  assign timeout     = in_get && timer_expire && !rx_done_tick;

  frame_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_frame_timer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (timer_clear),
    .expire_o(timer_expire)
  );

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    result_d    = result_q;
    tx_start_c  = 1'b0;
    frame_err_c = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
    chk_d = chk_q;
    err_d = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rx_done_tick) begin
          alu_op_d   = rx_data[OP_W-1:0];
          byte_cnt_d = '0;
          state_d    = GET_A;
`ifdef UART_FRAME_CHECKSUM_EN
          chk_d = rx_data;
`endif
        end
      end
      GET_A, GET_B: begin
        if (rx_done_tick) begin
          if (state_q == GET_A) begin
            alu_a_d[lane_lsb +: BYTE_W] = rx_data;
          end else begin
            alu_b_d[lane_lsb +: BYTE_W] = rx_data;
          end
`ifdef UART_FRAME_CHECKSUM_EN
          chk_d = chk_q ^ rx_data;
`endif
          if (last_lane) begin
            byte_cnt_d = '0;
            if (state_q == GET_A) begin
              state_d = GET_B;
            end else begin
`ifdef UART_FRAME_CHECKSUM_EN
              state_d = GET_CHK;
`else
              state_d = EXEC;
`endif
            end
          end else begin
            byte_cnt_d = byte_cnt_q + BC_W'(1);
          end
        end else if (timeout) begin
          state_d     = IDLE;
          frame_err_c = 1'b1;
        end
      end
`ifdef UART_FRAME_CHECKSUM_EN
      GET_CHK: begin
        if (rx_done_tick) begin
          if (rx_data == chk_q) begin
            state_d = EXEC;
          end else begin
            err_d       = 1'b1;
            frame_err_c = 1'b1;
            byte_cnt_d  = '0;
            state_d     = SEND;
          end
        end else if (timeout) begin
          state_d     = IDLE;
          frame_err_c = 1'b1;
        end
      end
`endif
      EXEC: begin
        result_d    = alu_result;
        byte_cnt_d  = '0;
        state_d     = SEND;
        frame_err_c = rx_done_tick;
      end
      SEND: begin
        tx_start_c  = 1'b1;
        state_d     = WAIT_TX;
        frame_err_c = rx_done_tick;
      end
      WAIT_TX: begin
        frame_err_c = rx_done_tick;
        if (tx_done_tick) begin
          if (tx_last) begin
            state_d = IDLE;
`ifdef UART_FRAME_CHECKSUM_EN
            err_d = 1'b0;
`endif
          end else begin
            byte_cnt_d = byte_cnt_q + BC_W'(1);
            state_d    = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      result_q   <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
      chk_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      result_q   <= result_d;
`ifdef UART_FRAME_CHECKSUM_EN
      chk_q <= chk_d;
      err_q <= err_d;
`endif
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign busy      = (state_q != IDLE);
  assign tx_start  = tx_start_c && !reset;
  assign frame_err = frame_err_c && !reset;

`ifdef UART_FRAME_CHECKSUM_EN
  assign tx_data = err_q ? ERR_BYTE : result_q[lane_lsb +: BYTE_W];
`else
  assign tx_data = result_q[lane_lsb +: BYTE_W];
`endif

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Bench for uart_alu_frame_ctrl: ALU model, UART tx model, and a scoreboard of expected tx bytes.
`timescale 1ns/1ps
module tb_uart_alu_frame_ctrl;
  import uart_alu_pkg::*;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned NB     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_done_tick;
  logic [7:0]        rx_data;
  logic              tx_done_tick = 1'b0;
  logic [DATA_W-1:0] alu_result;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic              tx_start, busy, frame_err;
  logic [7:0]        tx_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_rx_cyc = 0, last_err_cyc = 0, last_done_cyc = 0, busy_fall_cyc = 0;
  int tx_cnt = 0, err_cnt = 0;
  int tx_cyc_log [256];
  int tx_timer = 0;
  logic busy_prev = 1'b0;
  logic [7:0] exp_q [$];

  uart_alu_frame_ctrl #(
    .DATA_W     (DATA_W),
    .OP_W       (OP_W),
    .TIMEOUT_CYC(50)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_done_tick(rx_done_tick),
    .rx_data     (rx_data),
    .tx_done_tick(tx_done_tick),
    .alu_result  (alu_result),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] ref_alu(input logic [5:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SRA:  return DATA_W'($signed(a) >>> b[3:0]);
      OP_SRL:  return a >> b[3:0];
      default: return '0;
    endcase
  endfunction

  always_comb alu_result = ref_alu(alu_op, alu_a, alu_b);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART transmitter model: tx_done_tick six cycles after each tx_start.
  always @(posedge clk) begin
    #1;
    tx_done_tick = 1'b0;
    if (tx_start) begin
      tx_timer = 6;
    end else if (tx_timer > 0) begin
      tx_timer--;
      if (tx_timer == 0) tx_done_tick = 1'b1;
    end
  end

  // Monitor: event log plus scoreboard pop on every transmitted byte.
  always @(negedge clk) begin
    cyc++;
    if (rx_done_tick) last_rx_cyc = cyc;
    if (tx_done_tick) last_done_cyc = cyc;
    if (frame_err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (busy_prev && !busy) busy_fall_cyc = cyc;
    busy_prev = busy;
    if (tx_start) begin
      if (tx_cnt < 256) tx_cyc_log[tx_cnt] = cyc;
      tx_cnt++;
      if (exp_q.size() == 0) check_eq("tx_unexpected", {56'h0, tx_data}, 64'h1_0000);
      else check_eq("tx_byte", {56'h0, tx_data}, {56'h0, exp_q.pop_front()});
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_done_tick = 1'b1;
    rx_data      = b;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic send_operands(input logic [7:0] opb, input logic [DATA_W-1:0] a,
                               input logic [DATA_W-1:0] b, output logic [7:0] chk);
    chk = opb;
    send_byte(opb);
    for (int unsigned i = 0; i < NB; i++) begin
      repeat (2) @(posedge clk);
      send_byte(a[8*i +: 8]);
      chk = chk ^ a[8*i +: 8];
    end
    for (int unsigned i = 0; i < NB; i++) begin
      repeat (2) @(posedge clk);
      send_byte(b[8*i +: 8]);
      chk = chk ^ b[8*i +: 8];
    end
  endtask

  task automatic send_frame(input logic [7:0] opb, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    logic [7:0] chk;
    r = ref_alu(opb[5:0], a, b);
    for (int unsigned i = 0; i < NB; i++) exp_q.push_back(r[8*i +: 8]);
    send_operands(opb, a, b, chk);
`ifdef UART_FRAME_CHECKSUM_EN
    repeat (2) @(posedge clk);
    send_byte(chk);
`endif
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 400);
    if (busy) check_eq({tag, "_idle_timeout"}, {63'h0, busy}, 64'h0);
    @(posedge clk); #1;
  endtask

  task automatic wait_tx_start(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_start && n < 200);
    if (!tx_start) check_eq({tag, "_txstart_timeout"}, {63'h0, tx_start}, 64'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx0, e0;
    reset        = 1'b1;
    rx_done_tick = 1'b0;
    rx_data      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outs", {alu_op, alu_a, alu_b, tx_start, tx_data, busy, frame_err}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ADD 0x1234 + 0x0101 -> 0x35, 0x13
    tx0 = tx_cnt; e0 = err_cnt;
    send_frame(8'h20, 16'h1234, 16'h0101);
    wait_idle("t1");
    check_eq("t1_ntx", tx_cnt - tx0, 2);
    check_eq("t1_latency", tx_cyc_log[tx0] - last_rx_cyc, 2);
    check_eq("t1_busy_fall", busy_fall_cyc - last_done_cyc, 1);
    check_eq("t1_no_err", err_cnt - e0, 0);

    // SUB 0 - 1 -> 0xFFFF, operands held afterwards
    tx0 = tx_cnt;
    send_frame(8'h22, 16'h0000, 16'h0001);
    wait_idle("t2");
    repeat (10) @(posedge clk); #1;
    check_eq("t2_ntx", tx_cnt - tx0, 2);
    check_eq("t2_alu_a_held", alu_a, 16'h0000);
    check_eq("t2_alu_b_held", alu_b, 16'h0001);
    check_eq("t2_alu_op_held", alu_op, 6'h22);

    // Timeout in GET_A: error 49 cycles after last byte, partial A kept, no transmit
    tx0 = tx_cnt; e0 = err_cnt;
    send_byte(8'h20);
    repeat (2) @(posedge clk);
    send_byte(8'h34);
    repeat (60) @(posedge clk); #1;
    check_eq("t3_err_pulses", err_cnt - e0, 1);
    check_eq("t3_err_cycle", last_err_cyc - last_rx_cyc, 49);
    check_eq("t3_no_tx", tx_cnt - tx0, 0);
    check_eq("t3_idle", {63'h0, busy}, 64'h0);
    check_eq("t3_partial_a", alu_a, 16'h0034);
    tx0 = tx_cnt;
    send_frame(8'h20, 16'hBEEF, 16'h0111);
    wait_idle("t3b");
    check_eq("t3b_ntx", tx_cnt - tx0, 2);

    // Extra byte during WAIT_TX is dropped with an error pulse
    tx0 = tx_cnt; e0 = err_cnt;
    send_frame(8'h26, 16'hA5A5, 16'h0FF0);
    wait_tx_start("t4");
    send_byte(8'h55);
    wait_idle("t4");
    repeat (5) @(posedge clk); #1;
    check_eq("t4_err_pulses", err_cnt - e0, 1);
    check_eq("t4_err_cycle", last_err_cyc - last_rx_cyc, 0);
    check_eq("t4_ntx", tx_cnt - tx0, 2);
    check_eq("t4_no_new_frame", {63'h0, busy}, 64'h0);
    check_eq("t4_op_kept", alu_op, 6'h26);

    // Reset while waiting on the transmitter
    send_frame(8'h24, 16'hF0F0, 16'h3C3C);
    wait_tx_start("t5");
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_eq("t5_rst_cycle", {tx_start, frame_err}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_eq("t5_outs_zero", {alu_op, alu_a, alu_b, tx_start, tx_data, busy, frame_err}, 64'h0);
    repeat (10) @(posedge clk); #1;
    tx0 = tx_cnt;
    send_frame(8'h25, 16'h00F0, 16'h0F00);
    wait_idle("t5b");
    check_eq("t5b_ntx", tx_cnt - tx0, 2);
    check_eq("t5b_alu_a", alu_a, 16'h00F0);

`ifdef UART_FRAME_CHECKSUM_EN
    // Good checksum 0x06 then bad checksum 0x07
    begin
      logic [7:0] chk;
      tx0 = tx_cnt; e0 = err_cnt;
      send_frame(8'h20, 16'h1234, 16'h0101);
      wait_idle("t6a");
      check_eq("t6a_ntx", tx_cnt - tx0, 2);
      tx0 = tx_cnt;
      exp_q.push_back(8'hEE);
      send_operands(8'h20, 16'h1234, 16'h0101, chk);
      check_eq("t6_chk_model", {56'h0, chk}, 64'h06);
      repeat (2) @(posedge clk);
      send_byte(8'h07);
      wait_idle("t6b");
      check_eq("t6b_ntx", tx_cnt - tx0, 1);
      check_eq("t6b_err_pulses", err_cnt - e0, 1);
    end
`endif

    repeat (5) @(posedge clk); #1;
    check_eq("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
